// File: rtl/feature_row_streamer_pkg.sv
// Shared sizing and FSM encoding for the feature-map row streamer.
package feature_row_streamer_pkg;

  localparam int F       = 14;
  localparam int B       = 8;
  localparam int ICH     = 16;
  localparam int PRELOAD = 4;

  localparam int PRELOAD_EFF = (PRELOAD < F) ? PRELOAD : F;

  function automatic int calc_aw(input int f);
    return (f * f > 1) ? $clog2(f * f) : 1;
  endfunction

  localparam int AW = calc_aw(F);
  localparam int RW = (F > 1) ? $clog2(F) : 1;
  localparam int CW = $clog2(F + 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DRAIN} state_e;

endpackage

// File: rtl/feature_row_streamer_credit.sv
// Rising-edge detector on the freed-line interrupt plus a saturating row-credit counter.
module row_credit_counter
  import feature_row_streamer_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          intr,
  input  logic          evt_en,
  input  logic          load,
  input  logic          consume,
  output logic [CW-1:0] credit
);

  logic          intr_prev_q, intr_prev_d;
  logic [CW-1:0] credit_q, credit_d;
  logic          add;

  always_comb begin
    intr_prev_d = intr;
    add         = intr & ~intr_prev_q & evt_en;
    credit_d    = credit_q;
    if (load) begin
      credit_d = CW'(PRELOAD_EFF);
    end else if (add && !consume) begin
      if (credit_q != CW'(F)) credit_d = credit_q + CW'(1);
    end else if (consume && !add) begin
      if (credit_q != '0) credit_d = credit_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      intr_prev_q <= 1'b0;
      credit_q    <= '0;
    end else begin
      intr_prev_q <= intr_prev_d;
      credit_q    <= credit_d;
    end
  end

  assign credit = credit_q;

endmodule

// File: rtl/feature_row_streamer.sv
// Streams a stored F x F feature map row by row into the line-buffer controller,
// pacing rows after the preload by credits returned through i_intr[0].
module feature_row_streamer
  import feature_row_streamer_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [ICH-1:0]     i_intr,
  output logic               o_mem_rd,
  output logic [AW-1:0]      o_mem_addr,
  input  logic [ICH*B-1:0]   i_mem_data,
  output logic [ICH*B-1:0]   o_pixel_data,
  output logic [ICH-1:0]     o_pixel_data_valid,
  output logic               o_busy,
  output logic               o_done
);

  state_e             state_q, state_d;
  logic [RW-1:0]      row_q, row_d;
  logic [RW-1:0]      col_q, col_d;
  logic               all_rows_q, all_rows_d;
  logic               rd_d1_q, rd_d1_d;
  logic               vld_q, vld_d;
  logic [ICH*B-1:0]   pix_q, pix_d;
  logic               done_q, done_d;
  logic               rd, load, consume, evt_en, last_col, last_row;
  logic [CW-1:0]      credit;
  logic               unused_intr_hi;

  assign unused_intr_hi = ^i_intr[ICH-1:1];

  row_credit_counter u_credit (
    .clk     (i_clk),
    .rst_n   (i_rst),
    .intr    (i_intr[0]),
    .evt_en  (evt_en),
    .load    (load),
    .consume (consume),
    .credit  (credit)
  );

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    all_rows_d = all_rows_q;
    rd         = 1'b0;
    load       = 1'b0;
    consume    = 1'b0;
    last_col   = (col_q == RW'(F - 1));
    last_row   = (row_q == RW'(F - 1));
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d    = SEND;
          row_d      = '0;
          col_d      = '0;
          all_rows_d = 1'b0;
          load       = 1'b1;
        end
      end
      SEND: begin
        rd      = 1'b1;
        consume = (col_q == '0);
        if (consume && last_row) all_rows_d = 1'b1;
        if (last_col) begin
          col_d = '0;
          if (last_row) begin
            row_d   = '0;
            state_d = DRAIN;
          end else begin
            row_d   = row_q + RW'(1);
            state_d = (credit != '0) ? SEND : WAIT;
          end
        end else begin
          col_d = col_q + RW'(1);
        end
      end
      WAIT: begin
        if (credit != '0) state_d = SEND;
      end
      DRAIN: begin
        // The final read is one stage from the output register here.
        if (rd_d1_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Valid has no ready: every cycle with valid high carries one pixel word the
  // controller must take; data holds between valids.
  always_comb begin
    evt_en  = ((state_q == SEND) || (state_q == WAIT)) && !all_rows_q;
    rd_d1_d = rd;
    vld_d   = rd_d1_q;
    pix_d   = rd_d1_q ? i_mem_data : pix_q;
    done_d  = (state_q == DRAIN) && rd_d1_q;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      all_rows_q <= 1'b0;
      rd_d1_q    <= 1'b0;
      vld_q      <= 1'b0;
      pix_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      all_rows_q <= all_rows_d;
      rd_d1_q    <= rd_d1_d;
      vld_q      <= vld_d;
      pix_q      <= pix_d;
      done_q     <= done_d;
    end
  end

  assign o_mem_rd           = rd;
  assign o_mem_addr         = AW'(row_q) * AW'(F) + AW'(col_q);
  assign o_pixel_data       = pix_q;
  assign o_pixel_data_valid = {ICH{vld_q}};
  assign o_done             = done_q;
  assign o_busy             = (state_q != IDLE) || done_q;

endmodule

// File: tb/tb_feature_row_streamer.sv
// Randomized bench for feature_row_streamer against a frame-level reference model.
module tb_feature_row_streamer;
  import feature_row_streamer_pkg::*;

  localparam int W = ICH * B;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           i_start = 1'b0;
  logic [ICH-1:0] i_intr = '0;
  logic           o_mem_rd;
  logic [AW-1:0]  o_mem_addr;
  logic [W-1:0]   mem_data = '0;
  logic [W-1:0]   o_pixel_data;
  logic [ICH-1:0] o_pixel_data_valid;
  logic           o_busy, o_done;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  // model state
  bit           model_active = 1'b0;
  int           reads = 0, rows_entered = 0, events = 0, rows_allowed = 0;
  int           stall = 0, cyc = 0, edge_cyc = 0, row_start_cyc = 0;
  int           frame_valids = 0, obs_valids = 0, run = 0, run_max = 0, done_count = 0;
  logic         rd1 = 1'b0, rd2 = 1'b0, prev_intr = 1'b0;
  logic [W-1:0] last_pix = '0, exp_data;
  logic         exp_valid, exp_done, exp_busy;

  feature_row_streamer dut (
    .i_clk              (clk),
    .i_rst              (rst_n),
    .i_start            (i_start),
    .i_intr             (i_intr),
    .o_mem_rd           (o_mem_rd),
    .o_mem_addr         (o_mem_addr),
    .i_mem_data         (mem_data),
    .o_pixel_data       (o_pixel_data),
    .o_pixel_data_valid (o_pixel_data_valid),
    .o_busy             (o_busy),
    .o_done             (o_done)
  );

  // clock / reset block
  always #5 clk = ~clk;

  function automatic logic [W-1:0] ram_word(input int a);
    logic [W-1:0] w;
    logic [7:0]   ab;
    ab = a[7:0];
    for (int i = 0; i < ICH; i++) w[B*i +: B] = ab ^ B'(i);
    return w;
  endfunction

  function automatic logic [ICH-1:0] intr_noise(input logic b0);
    logic [ICH-1:0] v;
    v    = ICH'($urandom);
    v[0] = b0;
    return v;
  endfunction

  // RAM model: one-cycle read latency, random garbage when not read
  always @(posedge clk) begin
    if (o_mem_rd) mem_data <= ram_word(int'(o_mem_addr));
    else          mem_data <= W'({$urandom, $urandom, $urandom, $urandom});
  end

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // compare process: expectations come from frame rules, not from DUT state
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      chk("reset_outputs", 160'({o_mem_rd, o_mem_addr, o_pixel_data, o_pixel_data_valid, o_busy, o_done}), '0);
      model_active = 1'b0;
      reads = 0; rows_entered = 0; events = 0; stall = 0;
      frame_valids = 0; obs_valids = 0; run = 0; run_max = 0;
      exp_q.delete();
      rd1 = 1'b0; rd2 = 1'b0; prev_intr = 1'b0; last_pix = '0;
    end else begin
      if (i_intr[0] && !prev_intr && model_active && rows_entered < F) begin
        events++;
        edge_cyc = cyc;
      end
      prev_intr    = i_intr[0];
      rows_allowed = (PRELOAD + events < F) ? PRELOAD + events : F;
      if (rows_allowed > F) rows_allowed = F;
      exp_busy  = model_active;
      exp_valid = rd2;

      if (model_active) begin
        if (reads % F != 0) begin
          chk("rd_midrow", 160'(o_mem_rd), 160'(1));
        end else if (reads < F * F && rows_entered < rows_allowed) begin
          if (o_mem_rd) stall = 0; else stall++;
          chk("row_gap", 160'(stall <= 2), 160'(1));
        end
      end else begin
        chk("rd_idle", 160'(o_mem_rd), 160'(0));
      end

      if (o_mem_rd) begin
        chk("rd_addr", 160'(o_mem_addr), 160'(reads));
        if (reads % F == 0) begin
          chk("row_credit", 160'((reads / F) < rows_allowed), 160'(1));
          rows_entered++;
          row_start_cyc = cyc;
        end
        exp_q.push_back(ram_word(reads));
        reads++;
      end

      chk("valid", 160'(o_pixel_data_valid), 160'({ICH{exp_valid}}));
      if (exp_valid) begin
        chk("pop_avail", 160'(exp_q.size() != 0), 160'(1));
        if (exp_q.size() != 0) begin
          exp_data = exp_q.pop_front();
          last_pix = exp_data;
        end
        frame_valids++;
      end
      chk("pixel_data", 160'(o_pixel_data), 160'(last_pix));
      exp_done = exp_valid && (frame_valids == F * F);
      chk("done", 160'(o_done), 160'(exp_done));
      chk("busy", 160'(o_busy), 160'(exp_busy));

      if (o_pixel_data_valid[0]) begin
        obs_valids++;
        run++;
        if (run > run_max) run_max = run;
      end else begin
        run = 0;
      end

      rd2 = rd1;
      rd1 = o_mem_rd;
      if (exp_done) begin
        model_active = 1'b0;
        done_count++;
      end
      if (i_start && !model_active) begin
        model_active = 1'b1;
        reads = 0; rows_entered = 0; events = 0; stall = 0;
        frame_valids = 0; obs_valids = 0; run = 0; run_max = 0;
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_start = 1'b0;
    i_intr = '0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick(1);
    i_start = 1'b0;
  endtask

  task automatic pulse_intr(input int w);
    i_intr = intr_noise(1'b1);
    tick(w);
    i_intr = intr_noise(1'b0);
    tick(1);
  endtask

  task automatic run_full_frame(input string tag);
    int d0;
    int n;
    d0 = done_count;
    pulse_start();
    for (int k = 0; k < 10; k++) begin
      tick($urandom_range(2, 25));
      pulse_intr($urandom_range(1, 3));
    end
    pulse_start();
    pulse_intr(1);
    n = 0;
    while (done_count == d0 && n < 2000) begin
      tick(1);
      n++;
    end
    chk({tag, "_done_seen"}, 160'(done_count), 160'(d0 + 1));
    chk({tag, "_valids"}, 160'(obs_valids), 160'(F * F));
    pulse_intr(2);
    tick(30);
    chk({tag, "_post_valids"}, 160'(obs_valids), 160'(F * F));
    chk({tag, "_post_done"}, 160'(done_count), 160'(d0 + 1));
    chk({tag, "_post_busy"}, 160'(o_busy), 160'(0));
  endtask

  initial begin
    int d;
    int n;
    do_reset();
    chk("reset_state", 160'({o_mem_rd, o_mem_addr, o_pixel_data_valid, o_busy, o_done}), '0);

    // preload only: four rows then wait for credit
    pulse_start();
    tick(100);
    chk("t1_valids", 160'(obs_valids), 160'(56));
    chk("t1_rd_low", 160'(o_mem_rd), 160'(0));
    chk("t1_busy", 160'(o_busy), 160'(1));
    chk("t1_no_done", 160'(done_count), 160'(0));

    // one interrupt releases exactly one row
    pulse_intr(1);
    tick(40);
    chk("t2_valids", 160'(obs_valids), 160'(70));
    d = row_start_cyc - edge_cyc;
    chk("t2_latency", 160'(d >= 1 && d <= 2), 160'(1));

    // a held interrupt is a single event
    repeat (20) begin
      i_intr = intr_noise(1'b1);
      tick(1);
    end
    i_intr = intr_noise(1'b0);
    tick(30);
    chk("t3_valids", 160'(obs_valids), 160'(84));

    // credits accumulated during row 0 give a gap-free burst of eight rows
    do_reset();
    pulse_start();
    tick(1);
    repeat (4) pulse_intr(1);
    tick(150);
    chk("t4_valids", 160'(obs_valids), 160'(112));
    chk("t4_run", 160'(run_max), 160'(112));

    // full frame with extra start and interrupts
    do_reset();
    run_full_frame("t5");

    // reset in the middle of row 2
    do_reset();
    pulse_start();
    n = 0;
    while (reads < 2 * F + 5 && n < 200) begin
      tick(1);
      n++;
    end
    chk("t6_reach_row2", 160'(reads >= 2 * F + 5), 160'(1));
    rst_n = 1'b0;
    #1;
    chk("t6_async_clear", 160'({o_mem_rd, o_mem_addr, o_pixel_data, o_pixel_data_valid, o_busy, o_done}), '0);
    tick(3);
    rst_n = 1'b1;
    tick(5);
    chk("t6_no_stale_valid", 160'(obs_valids), 160'(0));
    run_full_frame("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
